mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Main control unit for the multicycle MIPS core: a Moore state machine that sequences fetch, decode, address/execute, memory and write-back steps for each instruction. It sits directly upstream of the ALU-control decoder, driving the 2-bit `alu_op` that decoder combines with `funct`. It also drives every datapath mux select and write enable (PC, IR, register file, memory), and stalls on a single-bit memory-ready handshake.

## Interface
Parameters:
- none (opcodes, states and ALU-op codes live in the package)

Ports:
- `clk` in 1: rising-edge clock
- `rst_n` in 1: asynchronous, active-low reset
- `opcode` in 6: instr[31:26] from the IR; sampled only in DECODE
- `zero` in 1: ALU zero flag
- `mem_ready` in 1: memory completes the current access this cycle
- `alu_op` out 2: to ALU control; 00 add, 01 subtract, 10 use funct
- `alu_src_a` out 1: 0 PC, 1 register A
- `alu_src_b` out 2: 00 register B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2
- `pc_src` out 2: 00 ALU result, 01 ALUOut, 10 jump target
- `iord` out 1: memory address from 0 PC, 1 ALUOut
- `reg_dst` out 1: write register 0 rt, 1 rd
- `mem_to_reg` out 1: write data 0 ALUOut, 1 MDR
- `ir_write`, `mem_write`, `reg_write` out 1 each: write enables
- `pc_en` out 1: `pc_write | (branch & zero)`
- `instr_done` out 1: one-cycle pulse on the last cycle of each instruction
- `illegal_op` out 1: one-cycle pulse in DECODE for an unsupported opcode

## Operation
- States, 4-bit encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11. Codes 12-15 go to FETCH.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- All outputs are decoded from the state register only (Moore); `pc_en` also uses `zero`. Any signal not listed for a state is 0.
- FETCH: `alu_src_b`=01. `ir_write` and `pc_write` equal `mem_ready`. Stay while `mem_ready`=0, else go to DECODE.
- DECODE: `alu_src_b`=11. Next state: lw/sw to MEMADR, R-type to EXECUTE, beq to BRANCH, addi to ADDIEXEC, j to JUMP. Any other opcode pulses `illegal_op` and goes to FETCH.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10. lw goes to MEMREAD, sw to MEMWRITE, using the opcode latched in DECODE.
- MEMREAD: `iord`=1. Stay until `mem_ready`, then go to MEMWB.
- MEMWB: `mem_to_reg`=1, `reg_write`=1.
- MEMWRITE: `iord`=1, `mem_write`=1, held until the cycle `mem_ready`=1. The write completes in that cycle.
- EXECUTE: `alu_src_a`=1, `alu_op`=10. Then ALUWB: `reg_dst`=1, `reg_write`=1.
- BRANCH: `alu_src_a`=1, `alu_op`=01, `pc_src`=01, `branch`=1.
- ADDIEXEC: `alu_src_a`=1, `alu_src_b`=10. Then ADDIWB: `reg_write`=1.
- JUMP: `pc_src`=10, `pc_write`=1.
- MEMWB, MEMWRITE (completing cycle), ALUWB, ADDIWB, BRANCH and JUMP return to FETCH and assert `instr_done`.

## Timing
- Reset (`rst_n`=0) sets the state to FETCH immediately. While `rst_n`=0, all write enables, `pc_en`, `instr_done` and `illegal_op` are forced to 0; all selects read 0.
- Reset mid-instruction abandons it with no partial writes.
- The first FETCH write occurs on the first rising edge after `rst_n` rises with `mem_ready`=1.
- Cycles per instruction with `mem_ready` held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each `mem_ready`=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- The opcode is captured at the DECODE→next edge. Later changes to `opcode` are ignored until the next DECODE.
- `zero` is used only in BRANCH. A taken branch gives `pc_en`=1 for exactly that one cycle.

## Structure
- Package `mips_ctrl_pkg` holds:
  - the state enum `ctrl_state_e`
  - opcode localparams: `OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_ADDI`, `OP_J`
  - ALU-op constants: `ALUOP_ADD`, `ALUOP_SUB`, `ALUOP_FUNCT`
  - the packed struct `ctrl_word_t` containing all select and enable fields
- One sub-module, `mips_ctrl_outdec`: purely combinational, maps state to `ctrl_word_t`. The top keeps the state register, next-state logic, the latched opcode and the reset gating.

## Test plan
- lw, `mem_ready`=1: `ir_write`/`pc_en` in cycle 0, `alu_src_b`=11 in cycle 1, `alu_src_b`=10 in cycle 2, `iord`=1 in cycle 3, `reg_write`/`mem_to_reg`/`instr_done` in cycle 4.
- sw with `mem_ready` low for 2 cycles in MEMWRITE: `mem_write`=1 for 3 consecutive cycles, `instr_done` on the third, total 6 cycles.
- R-type then addi back-to-back: `alu_op`=10 in EXECUTE, `reg_dst`=1 in ALUWB; then `alu_op`=00 and `reg_dst`=0 for addi. Each instruction takes 4 cycles.
- beq with `zero`=1: `pc_en`=1, `pc_src`=01 in cycle 2. With `zero`=0: `pc_en`=0, and `instr_done` is still asserted.
- `opcode`=111111: `illegal_op` pulses in DECODE, FETCH follows, and no write enable is asserted after the initial fetch.
- `rst_n` dropped asynchronously in MEMREAD: all enables 0 immediately, FETCH after release, and `mem_ready`=0 stalls in FETCH.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types for the multicycle MIPS control unit: state codes, opcodes,
// ALU-op codes and the datapath control word.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } ctrl_state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       iord;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       pc_write;
        logic       branch;
        logic       done;
    } ctrl_word_t;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// State-to-control-word decode, purely combinational (zero latency).
// No flow control of its own; memory-ready qualification happens in the top.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  ctrl_state_e state,
    output ctrl_word_t  cw
);

    always_comb begin
        cw = '0;
        unique case (state)
            S_FETCH: begin
                cw.alu_src_b = 2'b01;
                cw.ir_write  = 1'b1;
                cw.pc_write  = 1'b1;
            end
            S_DECODE: begin
                cw.alu_src_b = 2'b11;
            end
            S_MEMADR: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = 2'b10;
            end
            S_MEMREAD: begin
                cw.iord = 1'b1;
            end
            S_MEMWB: begin
                cw.mem_to_reg = 1'b1;
                cw.reg_write  = 1'b1;
                cw.done       = 1'b1;
            end
            S_MEMWRITE: begin
                cw.iord      = 1'b1;
                cw.mem_write = 1'b1;
                cw.done      = 1'b1;
            end
            S_EXECUTE: begin
                cw.alu_src_a = 1'b1;
                cw.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                cw.reg_dst   = 1'b1;
                cw.reg_write = 1'b1;
                cw.done      = 1'b1;
            end
            S_BRANCH: begin
                cw.alu_src_a = 1'b1;
                cw.alu_op    = ALUOP_SUB;
                cw.pc_src    = 2'b01;
                cw.branch    = 1'b1;
                cw.done      = 1'b1;
            end
            S_ADDIEXEC: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = 2'b10;
                cw.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                cw.reg_write = 1'b1;
                cw.done      = 1'b1;
            end
            S_JUMP: begin
                cw.pc_src   = 2'b10;
                cw.pc_write = 1'b1;
                cw.done     = 1'b1;
            end
            default: cw = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM; outputs decoded from the state register.
// Stalls in FETCH/MEMREAD/MEMWRITE until mem_ready; reset forces all outputs to 0.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       pc_en,
    output logic       instr_done,
    output logic       illegal_op
);

    ctrl_state_e state_q;
    logic [5:0]  op_q;
    ctrl_word_t  cw_raw;
    ctrl_word_t  cw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            op_q    <= OP_RTYPE;
        end else begin
            case (state_q)
                S_FETCH:
                    if (mem_ready) state_q <= S_DECODE;
                S_DECODE: begin
                    op_q <= opcode;
                    case (opcode)
                        OP_LW, OP_SW: state_q <= S_MEMADR;
                        OP_RTYPE:     state_q <= S_EXECUTE;
                        OP_BEQ:       state_q <= S_BRANCH;
                        OP_ADDI:      state_q <= S_ADDIEXEC;
                        OP_J:         state_q <= S_JUMP;
                        default:      state_q <= S_FETCH;
                    endcase
                end
                // lw/sw split relies on the opcode captured in DECODE, not the live IR field
                S_MEMADR:
                    state_q <= (op_q == OP_SW) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:
                    if (mem_ready) state_q <= S_MEMWB;
                S_MEMWRITE:
                    if (mem_ready) state_q <= S_FETCH;
                S_EXECUTE:  state_q <= S_ALUWB;
                S_ADDIEXEC: state_q <= S_ADDIWB;
                default:    state_q <= S_FETCH;
            endcase
        end
    end

    mips_ctrl_outdec u_outdec (
        .state (state_q),
        .cw    (cw_raw)
    );

    // Fetch writes and the store's done pulse wait on memory; reset overrides everything.
    always_comb begin
        cw = cw_raw;
        if (state_q == S_FETCH) begin
            cw.ir_write = mem_ready;
            cw.pc_write = mem_ready;
        end
        if (state_q == S_MEMWRITE) begin
            cw.done = mem_ready;
        end
        if (!rst_n) begin
            cw = '0;
        end
    end

    assign alu_op     = cw.alu_op;
    assign alu_src_a  = cw.alu_src_a;
    assign alu_src_b  = cw.alu_src_b;
    assign pc_src     = cw.pc_src;
    assign iord       = cw.iord;
    assign reg_dst    = cw.reg_dst;
    assign mem_to_reg = cw.mem_to_reg;
    assign ir_write   = cw.ir_write;
    assign mem_write  = cw.mem_write;
    assign reg_write  = cw.reg_write;
    assign pc_en      = cw.pc_write | (cw.branch & zero);
    assign instr_done = cw.done;
    assign illegal_op = rst_n && (state_q == S_DECODE) && !op_supported(opcode);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for the multicycle MIPS control FSM: a cycle-by-cycle vector table
// plus a hand-written asynchronous reset sequence.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       iord, reg_dst, mem_to_reg;
    logic       ir_write, mem_write, reg_write;
    logic       pc_en, instr_done, illegal_op;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .alu_op     (alu_op),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .iord       (iord),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .ir_write   (ir_write),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .pc_en      (pc_en),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    // Field order: alu_op, src_a, src_b, pc_src, iord, reg_dst, m2r, ir_w, mem_w, reg_w, pc_en, done, ill
    localparam logic [15:0] E_ZERO    = 16'b00_0_00_00_0_0_0_0_0_0_0_0_0;
    localparam logic [15:0] E_FETCH_R = 16'b00_0_01_00_0_0_0_1_0_0_1_0_0;
    localparam logic [15:0] E_FETCH_N = 16'b00_0_01_00_0_0_0_0_0_0_0_0_0;
    localparam logic [15:0] E_DEC     = 16'b00_0_11_00_0_0_0_0_0_0_0_0_0;
    localparam logic [15:0] E_DEC_ILL = 16'b00_0_11_00_0_0_0_0_0_0_0_0_1;
    localparam logic [15:0] E_MEMADR  = 16'b00_1_10_00_0_0_0_0_0_0_0_0_0;
    localparam logic [15:0] E_MEMRD   = 16'b00_0_00_00_1_0_0_0_0_0_0_0_0;
    localparam logic [15:0] E_MEMWB   = 16'b00_0_00_00_0_0_1_0_0_1_0_1_0;
    localparam logic [15:0] E_MEMW_N  = 16'b00_0_00_00_1_0_0_0_1_0_0_0_0;
    localparam logic [15:0] E_MEMW_R  = 16'b00_0_00_00_1_0_0_0_1_0_0_1_0;
    localparam logic [15:0] E_EXEC    = 16'b10_1_00_00_0_0_0_0_0_0_0_0_0;
    localparam logic [15:0] E_ALUWB   = 16'b00_0_00_00_0_1_0_0_0_1_0_1_0;
    localparam logic [15:0] E_BR_T    = 16'b01_1_00_01_0_0_0_0_0_0_1_1_0;
    localparam logic [15:0] E_BR_N    = 16'b01_1_00_01_0_0_0_0_0_0_0_1_0;
    localparam logic [15:0] E_ADDIEX  = 16'b00_1_10_00_0_0_0_0_0_0_0_0_0;
    localparam logic [15:0] E_ADDIWB  = 16'b00_0_00_00_0_0_0_0_0_1_0_1_0;
    localparam logic [15:0] E_JUMP    = 16'b00_0_00_10_0_0_0_0_0_0_1_1_0;

    typedef struct {
        logic [5:0]  op;
        logic        z;
        logic        rdy;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [15:0] outs();
        return {alu_op, alu_src_a, alu_src_b, pc_src, iord, reg_dst, mem_to_reg,
                ir_write, mem_write, reg_write, pc_en, instr_done, illegal_op};
    endfunction

    task automatic check(input string name, input logic [15:0] exp);
        logic [15:0] got;
        got = outs();
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic add(input logic [5:0] op, input logic z, input logic rdy,
                       input logic [15:0] exp, input string name);
        vec_t v;
        v.op = op; v.z = z; v.rdy = rdy; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b1;

        // Stall in FETCH, then lw with opcode changed to sw after DECODE (must be ignored)
        add(6'h00,  0, 0, E_FETCH_N, "fetch_stall");
        add(6'h00,  0, 1, E_FETCH_R, "lw_c0_fetch");
        add(6'h23,  0, 1, E_DEC,     "lw_c1_decode");
        add(6'h2b,  0, 1, E_MEMADR,  "lw_c2_memadr");
        add(6'h2b,  0, 0, E_MEMRD,   "lw_memread_stall");
        add(6'h2b,  0, 1, E_MEMRD,   "lw_c3_memread");
        add(6'h2b,  0, 1, E_MEMWB,   "lw_c4_memwb");
        // sw with two wait cycles in MEMWRITE
        add(6'h00,  0, 1, E_FETCH_R, "sw_fetch");
        add(6'h2b,  0, 1, E_DEC,     "sw_decode");
        add(6'h23,  0, 1, E_MEMADR,  "sw_memadr");
        add(6'h23,  0, 0, E_MEMW_N,  "sw_memw_wait1");
        add(6'h23,  0, 0, E_MEMW_N,  "sw_memw_wait2");
        add(6'h23,  0, 1, E_MEMW_R,  "sw_memw_done");
        // R-type then addi
        add(6'h3f,  0, 1, E_FETCH_R, "r_fetch");
        add(6'h00,  0, 1, E_DEC,     "r_decode");
        add(6'h08,  0, 1, E_EXEC,    "r_execute");
        add(6'h08,  0, 1, E_ALUWB,   "r_aluwb");
        add(6'h00,  0, 1, E_FETCH_R, "addi_fetch");
        add(6'h08,  0, 1, E_DEC,     "addi_decode");
        add(6'h00,  0, 1, E_ADDIEX,  "addi_exec");
        add(6'h00,  0, 1, E_ADDIWB,  "addi_wb");
        // beq taken, zero asserted outside BRANCH must not move the PC
        add(6'h00,  1, 1, E_FETCH_R, "beq_t_fetch");
        add(6'h04,  1, 1, E_DEC,     "beq_t_decode");
        add(6'h04,  1, 1, E_BR_T,    "beq_t_branch");
        add(6'h00,  0, 1, E_FETCH_R, "beq_n_fetch");
        add(6'h04,  1, 1, E_DEC,     "beq_n_decode");
        add(6'h04,  0, 1, E_BR_N,    "beq_n_branch");
        // jump
        add(6'h00,  0, 1, E_FETCH_R, "j_fetch");
        add(6'h02,  0, 1, E_DEC,     "j_decode");
        add(6'h02,  1, 1, E_JUMP,    "j_jump");
        // illegal opcode: back to FETCH, no write enables while stalled there
        add(6'h00,  0, 1, E_FETCH_R, "ill_fetch");
        add(6'h3f,  0, 1, E_DEC_ILL, "ill_decode");
        add(6'h3f,  0, 0, E_FETCH_N, "ill_refetch_stall");
        add(6'h3f,  0, 0, E_FETCH_N, "ill_refetch_stall2");
        add(6'h00,  0, 1, E_FETCH_R, "ill_refetch");

        #2;
        check("reset_outputs", E_ZERO);
        @(negedge clk);
        check("reset_outputs_held", E_ZERO);
        rst_n     = 1'b1;
        mem_ready = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            opcode    = vecs[i].op;
            zero      = vecs[i].z;
            mem_ready = vecs[i].rdy;
            #1;
            check(vecs[i].name, vecs[i].exp);
        end

        // Asynchronous reset while lw waits in MEMREAD
        @(negedge clk); opcode = 6'h23; mem_ready = 1'b1; #1; check("rst_seq_decode", E_DEC);
        @(negedge clk); #1; check("rst_seq_memadr", E_MEMADR);
        @(negedge clk); mem_ready = 1'b0; #1; check("rst_seq_memread", E_MEMRD);
        #1;
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        zero      = 1'b1;
        #1;
        check("rst_async_immediate", E_ZERO);
        @(negedge clk);
        check("rst_async_held", E_ZERO);
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        zero      = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_release_fetch", E_FETCH_N);
        @(negedge clk); mem_ready = 1'b0; #1; check("rst_fetch_stall", E_FETCH_N);
        @(negedge clk); mem_ready = 1'b1; #1; check("rst_fetch_go", E_FETCH_R);
        @(negedge clk); opcode = 6'h02; #1; check("rst_next_decode", E_DEC);
        @(negedge clk); #1; check("rst_next_jump", E_JUMP);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
